// File: rtl/mrd_iter_ctrl.sv
// Iteration controller for the MRD matrix-inversion datapath: load, iterate, watchdog.
// Define MRD_CONV_CHECK_EN to end a run early once the residual drops to the threshold.
module mrd_iter_ctrl #(
    parameter int WIDTH   = 8,
    parameter int ITER_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ITER_W-1:0] cfg_iter,
    input  logic [WIDTH-1:0]  thresh,
    input  logic              dp_valid,
    input  logic [WIDTH-1:0]  resid,
    output logic              dp_load,
    output logic              dp_en,
    output logic              busy,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              done,
    output logic              conv,
    output logic              err
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_WAIT, S_CHECK, S_DONE
    } state_t;

    state_t            r_state;
    logic [ITER_W-1:0] r_count;
    logic [ITER_W-1:0] r_iter_cnt;
    logic [WD_W-1:0]   r_wd;
    logic              r_dp_load;
    logic              r_dp_en;
    logic              r_busy;
    logic              r_done;
    logic              r_conv;
    logic              r_err;

    logic [ITER_W:0]   w_iter_next;
    logic [ITER_W-1:0] w_iter_sat;
    logic              w_last;
    logic              w_hit;

    assign w_iter_next = {1'b0, r_iter_cnt} + 1'b1;
    assign w_iter_sat  = (&r_iter_cnt) ? r_iter_cnt : w_iter_next[ITER_W-1:0];
    assign w_last      = (w_iter_next == {1'b0, r_count});

`ifdef MRD_CONV_CHECK_EN
    logic [WIDTH-1:0] r_thresh;
    logic [WIDTH-1:0] r_resid;

    assign w_hit = (r_resid <= r_thresh);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_thresh <= '0;
            r_resid  <= '0;
        end else begin
            if (r_state == S_IDLE && start)
                r_thresh <= thresh;
            if (r_state == S_WAIT && dp_valid)
                r_resid <= resid;
        end
    end
`else
    logic w_unused;

    assign w_unused = ^{resid, thresh};
    assign w_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_iter_cnt <= '0;
            r_wd       <= '0;
            r_dp_load  <= 1'b0;
            r_dp_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_conv     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_dp_load <= 1'b0;
            r_dp_en   <= 1'b0;
            r_done    <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_count    <= (cfg_iter == '0) ? ITER_W'(1) : cfg_iter;
                        r_iter_cnt <= '0;
                        r_conv     <= 1'b0;
                        r_err      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_dp_load  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state <= S_RUN;
                    r_dp_en <= 1'b1;
                    r_wd    <= '0;
                end
                // watchdog counts from the dp_en cycle, so expiry lands TIMEOUT cycles later
                S_RUN: begin
                    r_state <= S_WAIT;
                    r_wd    <= r_wd + 1'b1;
                end
                S_WAIT: begin
                    if (dp_valid) begin
                        r_state <= S_CHECK;
                    end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                        r_state <= S_DONE;
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_CHECK: begin
                    r_iter_cnt <= w_iter_sat;
                    if (w_last || w_hit) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_conv  <= w_hit;
                    end else begin
                        r_state <= S_RUN;
                        r_dp_en <= 1'b1;
                        r_wd    <= '0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dp_load  = r_dp_load;
    assign dp_en    = r_dp_en;
    assign busy     = r_busy;
    assign iter_cnt = r_iter_cnt;
    assign done     = r_done;
    assign conv     = r_conv;
    assign err      = r_err;
endmodule

// File: tb/tb_mrd_iter_ctrl.sv
// Directed bench for mrd_iter_ctrl: latency, iteration count, timeout, reset.
// A small responder plays the datapath, answering each dp_en after a set delay.
module tb_mrd_iter_ctrl;
    localparam int W  = 8;
    localparam int IW = 8;
    localparam int TO = 16;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          start    = 1'b0;
    logic [IW-1:0] cfg_iter = '0;
    logic [W-1:0]  thresh   = '0;
    logic          dp_valid = 1'b0;
    logic [W-1:0]  resid    = '0;
    logic          dp_load, dp_en, busy, done, conv, err;
    logic [IW-1:0] iter_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_load = 0, n_en = 0, n_done = 0, n_ovl = 0;
    int load_cyc = 0, en_cyc = 0;
    int dly = 1, hold_iter = 0, rsp_idx = 0;
    logic [W-1:0] rvals [4];

    mrd_iter_ctrl #(.WIDTH(W), .ITER_W(IW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_iter(cfg_iter),
        .thresh(thresh), .dp_valid(dp_valid), .resid(resid),
        .dp_load(dp_load), .dp_en(dp_en), .busy(busy),
        .iter_cnt(iter_cnt), .done(done), .conv(conv), .err(err)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (dp_load === 1'b1) begin n_load++; load_cyc = cyc; end
        if (dp_en === 1'b1) begin n_en++; en_cyc = cyc; end
        if (done === 1'b1) n_done++;
        if (int'(dp_load) + int'(dp_en) + int'(done) > 1) n_ovl++;
    end

    initial forever begin
        @(negedge clk);
        if (!rst || dp_load === 1'b1) begin
            rsp_idx = 0;
        end else if (dp_en === 1'b1) begin
            rsp_idx++;
            if (rsp_idx != hold_iter) begin
                repeat (dly) @(posedge clk);
                #1;
                dp_valid = 1'b1;
                resid = rvals[(rsp_idx - 1) % 4];
                @(posedge clk);
                #1;
                dp_valid = 1'b0;
            end
        end
    end

    task automatic start_run(input logic [IW-1:0] ci, output int s);
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_iter = ci;
        s = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output int dc);
        ok = 1'b0;
        dc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) begin
                ok = 1'b1;
                dc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({dp_load, dp_en, busy, done, conv, err, iter_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {dp_load, dp_en, busy, done, conv, err, iter_cnt});
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || dp_load !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold busy=%b load=%b exp=0 0", busy, dp_load);
        end
        start = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_min_latency;
        int s, dc, e0;
        bit ok;
        dly = 1; hold_iter = 0; thresh = 8'd10;
        rvals = '{8'd50, 8'd50, 8'd50, 8'd50};
        e0 = n_en;
        start_run(8'd0, s);
        wait_done(40, ok, dc);
        checks++;
        if (!ok) begin failures++; $display("FAIL min_done_seen got=0 exp=1"); end
        checks++;
        if (dc - s !== 5) begin failures++; $display("FAIL min_done_cyc got=%0d exp=5", dc - s); end
        checks++;
        if (load_cyc - s !== 1) begin
            failures++; $display("FAIL min_load_cyc got=%0d exp=1", load_cyc - s);
        end
        checks++;
        if (en_cyc - s !== 2) begin failures++; $display("FAIL min_en_cyc got=%0d exp=2", en_cyc - s); end
        checks++;
        if (n_en - e0 !== 1) begin failures++; $display("FAIL min_en_count got=%0d exp=1", n_en - e0); end
        checks++;
        if ({busy, iter_cnt, conv, err} !== {1'b1, 8'd1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL min_status busy=%b iter=%0d conv=%b err=%b exp=1 1 0 0",
                     busy, iter_cnt, conv, err);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL min_after busy=%b done=%b exp=0 0", busy, done);
        end
    endtask

    task automatic test_three_iter;
        int s, dc, e0;
        bit ok;
        dly = 2; hold_iter = 0; thresh = 8'd10;
        rvals = '{8'd50, 8'd50, 8'd50, 8'd50};
        e0 = n_en;
        start_run(8'd3, s);
        wait_done(100, ok, dc);
        checks++;
        if (!ok || n_en - e0 !== 3) begin
            failures++; $display("FAIL three_en ok=%b got=%0d exp=3", ok, n_en - e0);
        end
        checks++;
        if ({iter_cnt, conv, err} !== {8'd3, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL three_status iter=%0d conv=%b err=%b exp=3 0 0", iter_cnt, conv, err);
        end
    endtask

    task automatic test_conv;
        int s, dc, e0;
        bit ok;
        dly = 1; hold_iter = 0; thresh = 8'd10;
        e0 = n_en;
`ifdef MRD_CONV_CHECK_EN
        rvals = '{8'd40, 8'd20, 8'd8, 8'd8};
        start_run(8'd10, s);
        wait_done(100, ok, dc);
        checks++;
        if (!ok || {iter_cnt, conv, err} !== {8'd3, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL conv_status ok=%b iter=%0d conv=%b err=%b exp=3 1 0",
                     ok, iter_cnt, conv, err);
        end
        checks++;
        if (n_en - e0 !== 3) begin failures++; $display("FAIL conv_en got=%0d exp=3", n_en - e0); end
        repeat (3) @(negedge clk);
        checks++;
        if (conv !== 1'b1) begin failures++; $display("FAIL conv_held got=%b exp=1", conv); end
`else
        rvals = '{8'd5, 8'd5, 8'd5, 8'd5};
        start_run(8'd4, s);
        wait_done(100, ok, dc);
        checks++;
        if (!ok || {iter_cnt, conv, err} !== {8'd4, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL noconv_status ok=%b iter=%0d conv=%b err=%b exp=4 0 0",
                     ok, iter_cnt, conv, err);
        end
        checks++;
        if (n_en - e0 !== 4) begin failures++; $display("FAIL noconv_en got=%0d exp=4", n_en - e0); end
`endif
    endtask

    task automatic test_timeout;
        int s, dc, e0;
        bit ok;
        dly = 1; hold_iter = 2; thresh = 8'd10;
        rvals = '{8'd50, 8'd50, 8'd50, 8'd50};
        e0 = n_en;
        start_run(8'd4, s);
        wait_done(200, ok, dc);
        checks++;
        if (!ok || dc - en_cyc !== TO) begin
            failures++; $display("FAIL tmo_latency ok=%b got=%0d exp=%0d", ok, dc - en_cyc, TO);
        end
        checks++;
        if ({iter_cnt, conv, err} !== {8'd1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL tmo_status iter=%0d conv=%b err=%b exp=1 0 1", iter_cnt, conv, err);
        end
        checks++;
        if (n_en - e0 !== 2) begin failures++; $display("FAIL tmo_en got=%0d exp=2", n_en - e0); end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL tmo_err_held got=%b exp=1", err); end
        hold_iter = 0;
        start_run(8'd1, s);
        @(negedge clk);
        #1;
        checks++;
        if (err !== 1'b0 || iter_cnt !== 8'd0) begin
            failures++; $display("FAIL tmo_clear err=%b iter=%0d exp=0 0", err, iter_cnt);
        end
        wait_done(40, ok, dc);
    endtask

    task automatic test_expiry_valid;
        int s, dc, e0;
        bit ok;
        dly = TO - 1; hold_iter = 0;
        e0 = n_en;
        start_run(8'd2, s);
        wait_done(200, ok, dc);
        checks++;
        if (!ok || {iter_cnt, err} !== {8'd2, 1'b0}) begin
            failures++;
            $display("FAIL expiry_status ok=%b iter=%0d err=%b exp=2 0", ok, iter_cnt, err);
        end
        checks++;
        if (n_en - e0 !== 2) begin failures++; $display("FAIL expiry_en got=%0d exp=2", n_en - e0); end
    endtask

    task automatic test_all_ones;
        int s, dc, e0;
        bit ok;
        dly = 1; hold_iter = 0;
        e0 = n_en;
        start_run(8'hFF, s);
        wait_done(1000, ok, dc);
        checks++;
        if (!ok || iter_cnt !== 8'hFF || n_en - e0 !== 255) begin
            failures++;
            $display("FAIL all_ones ok=%b iter=%0d en=%0d exp=255 255", ok, iter_cnt, n_en - e0);
        end
    endtask

    task automatic test_back_to_back;
        int dc, dc2, l0;
        bit ok;
        dly = 1; hold_iter = 0;
        l0 = n_load;
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_iter = 8'd1;
        wait_done(40, ok, dc);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (dp_load === 1'b1) break;
        end
        checks++;
        if (!ok || load_cyc !== dc + 2) begin
            failures++; $display("FAIL b2b_reload ok=%b got=%0d exp=%0d", ok, load_cyc, dc + 2);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(40, ok, dc2);
        checks++;
        if (!ok || n_load - l0 !== 2) begin
            failures++; $display("FAIL b2b_loads ok=%b got=%0d exp=2", ok, n_load - l0);
        end
    endtask

    task automatic test_reset_midrun;
        int s, dc, e0, d0, l0;
        bit ok;
        dly = 6; hold_iter = 0;
        d0 = n_done;
        l0 = n_load;
        start_run(8'd3, s);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (dp_en === 1'b1) break;
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_iter = 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (n_load - l0 !== 1 || busy !== 1'b1) begin
            failures++; $display("FAIL ign_start loads=%0d busy=%b exp=1 1", n_load - l0, busy);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({dp_load, dp_en, busy, done, conv, err, iter_cnt} !== '0) begin
            failures++;
            $display("FAIL midrun_reset got=%b exp=0",
                     {dp_load, dp_en, busy, done, conv, err, iter_cnt});
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        checks++;
        if (n_done !== d0) begin failures++; $display("FAIL midrun_no_done got=%0d exp=0", n_done - d0); end
        dly = 1;
        e0 = n_en;
        start_run(8'd2, s);
        wait_done(60, ok, dc);
        checks++;
        if (!ok || dc - s !== 8 || iter_cnt !== 8'd2 || err !== 1'b0 || n_en - e0 !== 2) begin
            failures++;
            $display("FAIL fresh_run ok=%b cyc=%0d iter=%0d err=%b en=%0d exp=1 8 2 0 2",
                     ok, dc - s, iter_cnt, err, n_en - e0);
        end
    endtask

    initial begin
        test_reset();
        test_min_latency();
        test_three_iter();
        test_conv();
        test_timeout();
        test_expiry_valid();
        test_all_ones();
        test_back_to_back();
        test_reset_midrun();
        checks++;
        if (n_ovl !== 0) begin failures++; $display("FAIL pulse_overlap got=%0d exp=0", n_ovl); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
